// File: rtl/reg_dump.sv
// reg_dump: debug/test read-out initiator for a register file.
// On start it walks addresses 0 .. 2**D-1, reading each register through the
// shared read port and presenting one {address, data} beat per register on a
// valid/ready stream. A scan can only be cut short by reset.
// Optional feature macro: REG_DUMP_CLEAR_EN -- when defined, each accepted beat
// also zeroes its register through the file's write port (clear-after-read).
// When undefined, the write port outputs are tied to 0.
module reg_dump #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [D-1:0] rf_raddr,
  input  logic [W-1:0] rf_rdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [D-1:0] out_addr,
  output logic [W-1:0] out_data,
  output logic         rf_we,
  output logic [D-1:0] rf_waddr,
  output logic [W-1:0] rf_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [D-1:0]   r_ptr;
  logic [D-1:0]   r_out_addr;
  logic [W-1:0]   r_out_data;
  logic           w_hs;
  logic           w_last;

  // A beat is accepted only while it is actually being presented.
  assign w_hs   = (r_state == SEND) && out_ready;
  // Last beat is recognised by comparing against all-ones, so the pointer
  // never has to wrap to detect the end of the scan.
  assign w_last = (r_ptr == {D{1'b1}});

  // State register; reset drops straight back to IDLE from anywhere.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state selection: start only matters in IDLE.
  always_comb begin
    // NOTE: assign a default first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = READ;
      READ: w_next = SEND;
      SEND: if (w_hs) w_next = w_last ? DONE : READ;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pointer and beat capture: the beat registers change only in READ, so the
  // presented address/data stay frozen for the whole SEND phase.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      if (r_state == IDLE && start) r_ptr <= '0;
      else if (w_hs && !w_last)     r_ptr <= r_ptr + 1'b1;
      if (r_state == READ) begin
        r_out_addr <= r_ptr;
        r_out_data <= rf_rdata;
      end
    end
  end

  // Outputs decoded from the current state plus the shared write-port drive.
  always_comb begin
    busy      = (r_state == READ) || (r_state == SEND);
    done      = (r_state == DONE);
    out_valid = (r_state == SEND);
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
`ifdef REG_DUMP_CLEAR_EN
    // Zero the entry at the same edge that accepts its beat.
    rf_we     = w_hs;
    rf_waddr  = w_hs ? r_out_addr : '0;
`endif
  end

  assign rf_raddr = r_ptr;
  assign out_addr = r_out_addr;
  assign out_data = r_out_data;

endmodule

// File: tb/tb_reg_dump.sv
// Testbench for reg_dump (W=8, D=2). Hosts a small register file model wired
// to the DUT's read/write ports and compares every streamed beat against a
// snapshot of the file contents taken when the scan is launched.
`timescale 1ns/1ps
module tb_reg_dump;
  localparam int W = 8;
  localparam int D = 2;
  localparam int N = 1 << D;
`ifdef REG_DUMP_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic         busy;
  logic         done;
  logic [D-1:0] rf_raddr;
  logic [W-1:0] rf_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [D-1:0] out_addr;
  logic [W-1:0] out_data;
  logic         rf_we;
  logic [D-1:0] rf_waddr;
  logic [W-1:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Register file model and the bench's own picture of its contents.
  logic [W-1:0] rf_mem [N];
  logic [W-1:0] shadow [N];
  logic         tb_we;
  logic [D-1:0] tb_waddr;
  logic [W-1:0] tb_wdata;

  reg_dump #(.W(W), .D(D)) dut (
    .CLK(CLK), .reset(reset), .start(start), .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 CLK = ~CLK;

  assign rf_rdata = rf_mem[rf_raddr];

  always @(posedge CLK) begin
    if (rf_we)      rf_mem[rf_waddr] <= rf_wdata;
    else if (tb_we) rf_mem[tb_waddr] <= tb_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input int a, input logic [W-1:0] v);
    tb_we    = 1'b1;
    tb_waddr = a[D-1:0];
    tb_wdata = v;
    step();
    tb_we    = 1'b0;
    shadow[a] = v;
  endtask

  task automatic load_default();
    write_reg(0, 8'h11);
    write_reg(1, 8'h22);
    write_reg(2, 8'h33);
    write_reg(3, 8'h44);
  endtask

  // One complete scan. mode 0: ready always high (exact cycle timing checked),
  // mode 1: random ready, mode 2: beat 1 stalled for 5 cycles.
  // noisy: random start pulses while the scan is running.
  task automatic run_scan(input int mode, input bit noisy);
    logic [W-1:0] exp_d [N];
    int           beat  = 0;
    int           dones = 0;
    int           wes   = 0;
    int           stall = 0;
    int           cyc   = 0;
    bit           pend  = 1'b0;
    bit           fin   = 1'b0;
    logic [D-1:0] h_a   = '0;
    logic [W-1:0] h_d   = '0;
    for (int a = 0; a < N; a++) exp_d[a] = shadow[a];
    while (!fin && cyc < 400) begin
      if (pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_addr", out_addr, h_a);
        check("hold_data", out_data, h_d);
      end
      if (busy && beat < N) check("raddr_tracks", rf_raddr, beat);
      if (mode == 0 && cyc == 1) begin
        check("read_busy", busy, 1);
        check("read_valid", out_valid, 0);
        check("read_raddr", rf_raddr, 0);
      end
      if (done) begin
        dones++;
        check("done_after_last", beat, N);
        if (mode == 0) check("done_cycle", cyc, 2 * N + 1);
        fin = 1'b1;
      end
      start = (cyc == 0) || (noisy && !fin && $urandom_range(0, 2) == 0);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(out_valid && beat == 1 && stall < 5);
      endcase
      if (mode == 2 && out_valid && beat == 1 && !out_ready) stall++;
      #1;
      if (out_valid && out_ready) begin
        if (beat < N) begin
          check("beat_addr", out_addr, beat);
          check("beat_data", out_data, exp_d[beat]);
          if (mode == 0) check("beat_cycle", cyc, 2 + 2 * beat);
        end else begin
          check("beat_count", beat + 1, N);
        end
        check("we_on_accept", rf_we, CLEAR);
        check("waddr_on_accept", rf_waddr, CLEAR ? 32'(beat[D-1:0]) : 32'd0);
        check("wdata_zero", rf_wdata, 0);
        if (rf_we) wes++;
        beat++;
        pend = 1'b0;
      end else begin
        check("we_quiet", rf_we, 0);
        pend = out_valid;
        h_a  = out_addr;
        h_d  = out_data;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check("scan_timeout", fin, 1);
    check("beats_total", beat, N);
    check("done_pulses", dones, 1);
    check("we_pulses", wes, CLEAR ? N : 0);
    if (mode == 2) check("stall_cycles", stall, 5);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_valid", out_valid, 0);
    if (CLEAR) for (int a = 0; a < N; a++) shadow[a] = '0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    tb_we     = 1'b0;
    tb_waddr  = '0;
    tb_wdata  = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr", out_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_raddr", rf_raddr, 0);
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    repeat (2) step();
    reset = 1'b0;
    step();

    // Basic scan with exact timing, then a second scan of the same contents.
    load_default();
    run_scan(0, 1'b0);
    run_scan(0, 1'b0);

    // Backpressure on beat 1.
    load_default();
    run_scan(2, 1'b0);

    // Start pulses during the scan are ignored.
    load_default();
    run_scan(0, 1'b1);

    // Asynchronous reset while beat 1 is presented and not accepted.
    load_default();
    start = 1'b1;
    out_ready = 1'b1;
    step();              // READ
    start = 1'b0;
    step();              // SEND beat 0, accepted at next edge
    step();              // READ beat 1
    out_ready = 1'b0;
    step();              // SEND beat 1, stalled
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_addr", out_addr, 1);
    check("pre_rst_data", out_data, shadow[1]);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_data", out_data, 0);
    check("async_addr", out_addr, 0);
    check("async_raddr", rf_raddr, 0);
    step();
    reset = 1'b0;
    if (CLEAR) shadow[0] = '0;
    step();
    run_scan(0, 1'b0);

    // Random contents, random backpressure, random start noise.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < N; a++) write_reg(a, W'($urandom));
      run_scan(1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Sequential scan controller that drives the read port of the register file and streams every register's contents out over a valid/ready interface. On `start`, it walks addresses 0 through 2**D-1 in order and emits one beat per register as an {address, data} pair. It sits beside the register file as the debug/test read-out initiator. It shares the file's `raddrA` port while busy, and optionally its write port for clear-after-read.

## Interface
- `W`, default 8: data path width; matches the register file.
- `D`, default 2: pointer width; the scan covers 2**D registers.

- `CLK` in 1: clock, rising-edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and clears all outputs.
- `start` in 1: begin a scan; sampled only in IDLE.
- `busy` out 1: high in READ and SEND.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `rf_raddr` out D: read address to the register file.
- `rf_rdata` in W: combinational read data returned for `rf_raddr`.
- `out_valid` out 1: a beat is presented.
- `out_ready` in 1: the consumer accepts the beat.
- `out_addr` out D: register index of the current beat.
- `out_data` out W: register contents of the current beat.
- `rf_we` out 1: write enable to the register file (clear feature).
- `rf_waddr` out D: write address (clear feature).
- `rf_wdata` out W: write data, always 0.

## Operation
- States: IDLE, READ, SEND, DONE. Pointer `ptr` is D bits wide.
- IDLE:
  - `busy`=0 and `out_valid`=0.
  - `start`=1 sets `ptr`=0 and moves to READ.
- READ:
  - `rf_raddr`=`ptr`.
  - At the clock edge, capture `rf_rdata` into `out_data` and `ptr` into `out_addr`, set `out_valid`=1, and move to SEND.
- SEND:
  - Hold `out_valid`=1. `out_data` and `out_addr` stay stable until a handshake (`out_valid`&&`out_ready`).
  - On a handshake with `ptr`==2**D-1: clear `out_valid` and go to DONE.
  - On any other handshake: increment `ptr`, clear `out_valid`, and go to READ.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `rf_raddr` equals `ptr` in every state, and 0 after reset.
- `start` is ignored in READ, SEND and DONE. A scan cannot be restarted or aborted except by `reset`.
- The pointer never wraps mid-scan. The last-beat test is a compare against all-ones, not a carry-out.
- Reset at any time, including mid-beat: the next state is IDLE immediately. All outputs go to 0: `busy`, `done`, `out_valid`, `out_addr`, `out_data`, `rf_raddr`, `rf_we`, `rf_waddr`, `rf_wdata`. A beat that was presented but not accepted is dropped.

## Timing
- With `start` high in cycle 0:
  - READ is in cycle 1.
  - The first `out_valid` is in cycle 2.
- With `out_ready` tied high, each beat takes 2 cycles, so 2**D beats take 2·2**D cycles.
- `done` is high in the cycle after the final handshake. IDLE follows one cycle later, and a new `start` is accepted there.
- Back-to-back `start` held high: the next scan begins in the first IDLE cycle.
- `out_ready` may toggle freely. The block never drops or repeats a beat, and never deasserts `out_valid` without a handshake.
- Read data is sampled in READ. A register-file write to the same address in that cycle appears in the next scan, not this one.

## Configuration
- Macro: `REG_DUMP_CLEAR_EN`.
- Defined (clear-after-read):
  - In the handshake cycle in SEND, `rf_we`=1, `rf_waddr`=`out_addr` and `rf_wdata`=0, all combinational.
  - The register file zeroes that entry at the same edge that accepts the beat.
  - After a complete scan, every register reads 0.
- Undefined:
  - `rf_we`, `rf_waddr` and `rf_wdata` are tied to 0.
  - The scan is non-destructive.

## Test plan
All scenarios use W=8, D=2, with the register file preloaded to 0x11, 0x22, 0x33, 0x44.

- Basic scan:
  - Stimulus: `start` pulse in cycle 0, `out_ready`=1.
  - Response: beats (0,0x11) in cycle 2, (1,0x22) in cycle 4, (2,0x33) in cycle 6, (3,0x44) in cycle 8; `done` in cycle 9; `busy`=0 in cycle 10.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles on beat 1.
  - Response: `out_valid`=1 with `out_addr`=1 and `out_data`=0x22 held unchanged; the sequence then continues with no duplicate beat.
- Ignored start:
  - Stimulus: `start` pulsed in SEND of beat 2.
  - Response: the scan is unaffected; exactly 4 beats and one `done`.
- Reset mid-operation:
  - Stimulus: assert `reset` asynchronously while beat 1 is valid.
  - Response: `out_valid`, `busy`, `out_data` and `rf_raddr` go to 0 without waiting for a clock edge. After release, `start` yields beat (0,0x11).
- Clear-after-read (`REG_DUMP_CLEAR_EN` defined):
  - Stimulus: run a full scan, then a second scan.
  - Response: the first scan returns 0x11 through 0x44; `rf_we` pulses exactly 4 times with `rf_waddr` = 0,1,2,3. The second scan returns all 0x00.
- Clear feature off (`REG_DUMP_CLEAR_EN` undefined):
  - Stimulus: run two scans.
  - Response: both return 0x11 through 0x44; `rf_we` stays 0 throughout.
